branch_resolve_unit: RTL and testbench

- Parametrised, registered successor to the combinational branch comparator.
- Takes a branch opcode, a test operand and the branch PC/offset through a valid/ready handshake.
- Evaluates the condition and computes the branch target.
- Presents one registered result with 1-cycle latency; on an accepted taken branch, drives a multi-cycle pipeline flush. Sits between the decode/ALU stage and the PC-select mux.

---
 rtl/bru_pkg.sv | 22 ++
 rtl/bru_cond_eval.sv | 37 +++
 rtl/branch_resolve_unit.sv | 141 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared opcode encodings, FSM state type and flush-counter sizing for the branch resolve unit.
package bru_pkg;

  localparam logic [4:0] OPC_BMI  = 5'b10000;
  localparam logic [4:0] OPC_BPL  = 5'b10001;
  localparam logic [4:0] OPC_BZ   = 5'b10010;
  localparam logic [4:0] OPC_BNZ  = 5'b10011;
  localparam logic [4:0] OPC_B    = 5'b10100;
  localparam logic [4:0] OPC_BGEZ = 5'b10101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } bru_state_t;

  // Width able to hold FLUSH_CYCLES; never below 1 so the counter is always declarable.
  function automatic int flush_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bru_cond_eval.sv
// Branch condition evaluator: pure combinational, zero latency, no flow control.
// Opcode bits above the 5-bit encoding must be zero to match; unknown opcodes are not taken.
module bru_cond_eval
  import bru_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] operand,
  output logic              taken
);

  logic w_z;
  logic w_n;
  logic w_hi_zero;

  assign w_z       = ~(|operand);
  assign w_n       = operand[DATA_W-1];
  assign w_hi_zero = ((opcode >> 5) == '0);

  always_comb begin
    taken = 1'b0;
    if (w_hi_zero) begin
      case (opcode[4:0])
        OPC_B:    taken = 1'b1;
        OPC_BMI:  taken = w_n;
        OPC_BPL:  taken = ~w_n & ~w_z;
        OPC_BZ:   taken = w_z;
        OPC_BNZ:  taken = ~w_z;
        OPC_BGEZ: taken = ~w_n;
        default:  taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: result 1 cycle after accept, then FLUSH_CYCLES of flush on a taken retire.
// Backpressure: result held while out_ready=0; in_ready drops while holding a taken result or flushing. Stats via BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int OPC_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] pc_next,
  input  logic [DATA_W-1:0] offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [DATA_W-1:0] target,
  output logic              flush,
  output logic              busy
`ifdef BRU_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_total,
  output logic [CNT_W-1:0]  stat_taken
`endif
);

  localparam int FCW = flush_cnt_w(FLUSH_CYCLES);

  bru_state_t        r_state;
  logic [FCW-1:0]    r_cnt;
  logic              r_taken;
  logic [DATA_W-1:0] r_target;

  bru_state_t        w_state_nxt;
  logic [FCW-1:0]    w_cnt_nxt;
  logic              w_taken_nxt;
  logic [DATA_W-1:0] w_target_nxt;
  logic              w_cond_taken;
  logic              w_accept;
  logic              w_retire;

  bru_cond_eval #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_cond (
    .opcode  (opcode),
    .operand (operand),
    .taken   (w_cond_taken)
  );

  // A taken result must not be overtaken: the flush has to follow it before new work enters.
  assign in_ready  = (r_state == IDLE) | ((r_state == HOLD) & out_ready & ~r_taken);
  assign w_accept  = in_valid & in_ready;
  assign w_retire  = (r_state == HOLD) & out_ready;

  assign out_valid = (r_state == HOLD);
  assign flush     = (r_state == FLUSH);
  assign busy      = (r_state != IDLE);
  assign taken     = r_taken;
  assign target    = r_target;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_taken_nxt  = r_taken;
    w_target_nxt = r_target;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (r_taken) begin
            if (FLUSH_CYCLES > 0) begin
              w_state_nxt = FLUSH;
              w_cnt_nxt   = FCW'(FLUSH_CYCLES);
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_state_nxt = w_accept ? HOLD : IDLE;
          end
        end
      end
      FLUSH: begin
        w_cnt_nxt = r_cnt - FCW'(1);
        if (r_cnt == FCW'(1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) begin
      w_taken_nxt  = w_cond_taken;
      w_target_nxt = w_cond_taken ? (pc_next + offset) : pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_taken  <= 1'b0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_taken  <= w_taken_nxt;
      r_target <= w_target_nxt;
    end
  end

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] r_stat_total;
  logic [CNT_W-1:0] r_stat_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_total <= '0;
      r_stat_taken <= '0;
    end else if (stat_clr) begin
      r_stat_total <= '0;
      r_stat_taken <= '0;
    end else if (w_retire) begin
      if (r_stat_total != '1) r_stat_total <= r_stat_total + CNT_W'(1);
      if (r_taken && (r_stat_taken != '1)) r_stat_taken <= r_stat_taken + CNT_W'(1);
    end
  end

  assign stat_total = r_stat_total;
  assign stat_taken = r_stat_taken;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (CNT_W > 0) & w_retire;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_branch_resolve_unit;
  localparam int DW = 32;
  localparam int OW = 5;
  localparam int FC = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] opcode = '0;
  logic [DW-1:0] operand = '0;
  logic [DW-1:0] pc_next = '0;
  logic [DW-1:0] offset = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          taken;
  logic [DW-1:0] target;
  logic          flush;
  logic          busy;
`ifdef BRU_STATS_EN
  logic          stat_clr = 1'b0;
  logic [CW-1:0] stat_total;
  logic [CW-1:0] stat_taken;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DATA_W(DW), .OPC_W(OW), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand(operand), .pc_next(pc_next), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .target(target), .flush(flush), .busy(busy)
`ifdef BRU_STATS_EN
    , .stat_clr(stat_clr), .stat_total(stat_total), .stat_taken(stat_taken)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: branch semantics straight from the opcode table.
  function automatic bit ref_taken(input logic [4:0] op, input logic [31:0] v);
    bit z, n;
    z = (v == 32'd0);
    n = v[31];
    case (op)
      5'b10100: return 1'b1;
      5'b10000: return n;
      5'b10001: return !n && !z;
      5'b10010: return z;
      5'b10011: return !z;
      5'b10101: return !n;
      default:  return 1'b0;
    endcase
  endfunction

  // Model: at most one outstanding result, then a countdown of flush cycles.
  bit        m_valid;
  bit        m_taken;
  bit [31:0] m_target;
  int        m_fl;
  int        m_tot;
  int        m_tk;

  function automatic bit model_ready(input bit ordy);
    return (!m_valid && m_fl == 0) || (m_valid && ordy && !m_taken);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc, ret, clr;
    if (!rst_n) begin
      m_valid = 0; m_taken = 0; m_target = 0; m_fl = 0; m_tot = 0; m_tk = 0;
    end else begin
      acc = in_valid && model_ready(out_ready);
      ret = m_valid && out_ready;
`ifdef BRU_STATS_EN
      clr = stat_clr;
`else
      clr = 1'b0;
`endif
      if (clr) begin
        m_tot = 0; m_tk = 0;
      end else if (ret) begin
        if (m_tot < CMAX) m_tot++;
        if (m_taken && m_tk < CMAX) m_tk++;
      end
      if (m_fl > 0) m_fl--;
      if (ret) begin
        m_valid = 0;
        if (m_taken) m_fl = FC;
      end
      if (acc) begin
        m_valid  = 1;
        m_taken  = ref_taken(opcode, operand);
        m_target = m_taken ? pc_next + offset : pc_next;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready(out_ready)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("flush", {31'd0, flush}, {31'd0, (m_fl > 0)});
    chk("busy", {31'd0, busy}, {31'd0, (m_valid || m_fl > 0)});
    if (m_valid) begin
      chk("taken", {31'd0, taken}, {31'd0, m_taken});
      chk("target", target, m_target);
    end
`ifdef BRU_STATS_EN
    chk("stat_total", 32'(stat_total), 32'(m_tot));
    chk("stat_taken", 32'(stat_taken), 32'(m_tk));
`endif
  end

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] v, input logic [31:0] pc, input logic [31:0] off);
    in_valid = 1'b1; opcode = op; operand = v; pc_next = pc; offset = off;
  endtask

  initial begin
    repeat (2) next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // BZ taken, then two flush cycles
    next_cyc();
    send(5'b10010, 32'd0, 32'h100, 32'h20); out_ready = 1'b1;
    next_cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("bz_valid", {31'd0, out_valid}, 32'd1);
    chk("bz_taken", {31'd0, taken}, 32'd1);
    chk("bz_target", target, 32'h120);
    next_cyc(); @(negedge clk);
    chk("bz_flush1", {31'd0, flush}, 32'd1);
    chk("bz_rdy1", {31'd0, in_ready}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("bz_flush2", {31'd0, flush}, 32'd1);
    next_cyc(); @(negedge clk);
    chk("bz_flush3", {31'd0, flush}, 32'd0);
    chk("bz_rdy3", {31'd0, in_ready}, 32'd1);

    // Back-to-back BMI (not taken) then BPL (taken)
    next_cyc();
    send(5'b10000, 32'h7FFFFFFF, 32'h200, 32'h40);
    next_cyc();
    send(5'b10001, 32'h1, 32'h300, 32'h10);
    @(negedge clk);
    chk("b2b_taken0", {31'd0, taken}, 32'd0);
    chk("b2b_target0", target, 32'h200);
    chk("b2b_rdy0", {31'd0, in_ready}, 32'd1);
    next_cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
    chk("b2b_taken1", {31'd0, taken}, 32'd1);
    chk("b2b_target1", target, 32'h310);
    repeat (3) next_cyc();

    // Stall on BNZ
    send(5'b10011, 32'd5, 32'h400, 32'h8); out_ready = 1'b0;
    next_cyc(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_target", target, 32'h408);
      chk("stall_rdy", {31'd0, in_ready}, 32'd0);
      next_cyc();
    end
    out_ready = 1'b1;
    next_cyc(); @(negedge clk);
    chk("stall_retired", {31'd0, out_valid}, 32'd0);
    chk("stall_flush", {31'd0, flush}, 32'd1);
    repeat (2) next_cyc();

    // Wrap-around target, then unknown opcode
    send(5'b10100, 32'd0, 32'hFFFFFFF0, 32'h20);
    next_cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_target", target, 32'h10);
    repeat (3) next_cyc();
    send(5'b11111, 32'd0, 32'h500, 32'h80);
    next_cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("unk_taken", {31'd0, taken}, 32'd0);
    chk("unk_target", target, 32'h500);
    next_cyc(); @(negedge clk);
    chk("unk_noflush", {31'd0, flush}, 32'd0);

    // Asynchronous reset while a taken result is held
    next_cyc();
    send(5'b10100, 32'd0, 32'h600, 32'h4); out_ready = 1'b0;
    next_cyc(); in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_taken", {31'd0, taken}, 32'd0);
    chk("arst_flush", {31'd0, flush}, 32'd0);
    next_cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rdy", {31'd0, in_ready}, 32'd1);

`ifdef BRU_STATS_EN
    next_cyc(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(5'b10100, 32'd0, 32'h700, 32'h4);
      next_cyc(); in_valid = 1'b0;
      repeat (3) next_cyc();
    end
    @(negedge clk);
    chk("sat_taken", 32'(stat_taken), 32'd3);
    next_cyc();
    send(5'b11111, 32'd0, 32'h800, 32'h4); out_ready = 1'b0;
    next_cyc(); in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b1;
    next_cyc(); stat_clr = 1'b0;
    @(negedge clk);
    chk("clr_total", 32'(stat_total), 32'd0);
    chk("clr_taken", 32'(stat_taken), 32'd0);
`endif

    // Randomized traffic
    next_cyc();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] ops [7];
      ops = '{5'b10100, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10101, 5'b00000};
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      opcode    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0: operand = 32'd0;
        1: operand = 32'h80000000 | $urandom;
        default: operand = $urandom;
      endcase
      pc_next = $urandom;
      offset  = $urandom;
`ifdef BRU_STATS_EN
      stat_clr = ($urandom_range(0, 31) == 0);
`endif
      next_cyc();
    end
    in_valid = 1'b0;
    repeat (5) next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
